// File: rtl/io_map_pkg.sv
// io_map_pkg: shared register map for the 0xFFF0-0xFFFF I/O window.
//   - Window base, per-register byte addresses.
//   - CTRL register bit positions (RDY, OVR).
//   - Value returned for unmapped window addresses.
//   - ctrl_next(): next-state rule for a RDY/OVR flag pair.
package io_map_pkg;

    localparam logic [11:0] IO_BASE     = 12'hFFF;

    localparam logic [15:0] IO_KDATA    = 16'hFFF0;
    localparam logic [15:0] IO_SDATA    = 16'hFFF2;
    localparam logic [15:0] IO_KCTRL    = 16'hFFF4;
    localparam logic [15:0] IO_SCTRL    = 16'hFFF6;
    localparam logic [15:0] IO_HEX      = 16'hFFF8;
    localparam logic [15:0] IO_LEDR     = 16'hFFFA;
    localparam logic [15:0] IO_LEDG     = 16'hFFFC;
    localparam logic [15:0] IO_TICK     = 16'hFFFE;

    localparam int          CTRL_RDY    = 0;
    localparam int          CTRL_OVR    = 2;

    localparam logic [15:0] IO_UNMAPPED = 16'hDEAD;

    typedef struct packed {
        logic ovr;
        logic rdy;
    } ctrl_t;

    // upd    : debounced value loads this edge
    // rd_clr : data-register read with re=1 this edge
    // wr_clr : CTRL write with the OVR bit written as 0
    // A fresh update always wins over a clearing read so no event is lost;
    // OVR is only raised when an unread RDY is being overwritten.
    function automatic ctrl_t ctrl_next(ctrl_t cur, logic upd, logic rd_clr, logic wr_clr);
        ctrl_t nxt;
        nxt = cur;
        if (wr_clr)
            nxt.ovr = 1'b0;
        if (upd) begin
            nxt.rdy = 1'b1;
            if (cur.rdy && !rd_clr)
                nxt.ovr = 1'b1;
        end else if (rd_clr) begin
            nxt.rdy = 1'b0;
        end
        return nxt;
    endfunction

    function automatic logic [15:0] ctrl_word(ctrl_t c);
        logic [15:0] w;
        w = '0;
        w[CTRL_RDY] = c.rdy;
        w[CTRL_OVR] = c.ovr;
        return w;
    endfunction

endpackage

// File: rtl/io_responder_if.sv
// io_responder_if: core-side load/store bus to the I/O responder.
//   addr  : byte address          wdata : store data
//   we    : store strobe          re    : load strobe (read side effects)
//   rdata : load data (comb)      sel   : address lies in the I/O window
// Modports: master = core, slave = responder.
interface io_responder_if #(
    parameter int DBITS = 16
);
    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] wdata;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rdata;
    logic             sel;

    modport master (output addr, wdata, we, re, input rdata, sel);
    modport slave  (input addr, wdata, we, re, output rdata, sel);
endinterface

// File: rtl/io_debounce.sv
// io_debounce: 2-flop synchronizer + stability counter + debounced register.
//   din     : raw asynchronous pins
//   dout    : debounced value (RST_VAL out of reset)
//   changed : high for the single cycle whose closing edge loads dout
// dout follows din only after the synchronized value has differed from
// dout for CYCLES consecutive cycles; pin-to-dout latency is 2 + CYCLES.
module io_debounce #(
    parameter int               WIDTH   = 4,
    parameter int               CYCLES  = 50000,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             changed
);
    localparam int CW = $clog2(CYCLES + 1);

    logic [WIDTH-1:0] sync1, sync2;
    logic [CW-1:0]    cnt;

    // Last counting cycle: the load happens on the edge that would make
    // the count reach CYCLES, so the counter never actually holds CYCLES.
    assign changed = (sync2 != dout) && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RST_VAL;
            sync2 <= RST_VAL;
            dout  <= RST_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (changed) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_responder.sv
// io_responder: memory-mapped I/O at 0xFFF0-0xFFFF on the core data bus.
//   clk, rst_n : clock, async active-low reset
//   bus        : io_responder_if.slave (addr/wdata/we/re in, rdata/sel out)
//   key_in     : raw KEY pins (active-low)   sw_in  : raw SW pins
//   hex_out    : HEX display register        ledr_out/ledg_out : LED registers
// Optional: define IO_TICK_TIMER_EN to map a free-running tick counter at
// 0xFFFE; otherwise that address reads 16'hDEAD and ignores writes.
module io_responder
    import io_map_pkg::*;
#(
    parameter int DBITS           = 16,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int TICK_CYCLES     = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    io_responder_if.slave       bus,
    input  logic [3:0]          key_in,
    input  logic [9:0]          sw_in,
    output logic [15:0]         hex_out,
    output logic [9:0]          ledr_out,
    output logic [7:0]          ledg_out
);
    logic [3:0]       key_deb;
    logic [9:0]       sw_deb;
    logic             key_chg, sw_chg;
    ctrl_t            kctrl, sctrl;
    logic             wr_en, rd_en;
    logic [DBITS-1:0] rdata_c;

    io_debounce #(.WIDTH(4), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(4'hF)) u_key_deb (
        .clk(clk), .rst_n(rst_n), .din(key_in), .dout(key_deb), .changed(key_chg)
    );

    io_debounce #(.WIDTH(10), .CYCLES(DEBOUNCE_CYCLES), .RST_VAL(10'h0)) u_sw_deb (
        .clk(clk), .rst_n(rst_n), .din(sw_in), .dout(sw_deb), .changed(sw_chg)
    );

    assign bus.sel = (bus.addr[15:4] == IO_BASE);
    assign wr_en   = bus.we & bus.sel;
    assign rd_en   = bus.re & bus.sel;

    // Status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kctrl <= '0;
            sctrl <= '0;
        end else begin
            kctrl <= ctrl_next(kctrl, key_chg,
                               rd_en && bus.addr == IO_KDATA,
                               wr_en && bus.addr == IO_KCTRL && !bus.wdata[CTRL_OVR]);
            sctrl <= ctrl_next(sctrl, sw_chg,
                               rd_en && bus.addr == IO_SDATA,
                               wr_en && bus.addr == IO_SCTRL && !bus.wdata[CTRL_OVR]);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_out  <= '0;
            ledr_out <= '0;
            ledg_out <= '0;
        end else if (wr_en) begin
            if (bus.addr == IO_HEX)  hex_out  <= bus.wdata[15:0];
            if (bus.addr == IO_LEDR) ledr_out <= bus.wdata[9:0];
            if (bus.addr == IO_LEDG) ledg_out <= bus.wdata[7:0];
        end
    end

`ifdef IO_TICK_TIMER_EN
    localparam int PW = $clog2(TICK_CYCLES + 1);

    logic [PW-1:0] presc;
    logic [15:0]   tick;

    // A store reloads the count and restarts the prescaler so the next
    // increment comes a full TICK_CYCLES later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= '0;
        end else if (wr_en && bus.addr == IO_TICK) begin
            presc <= '0;
            tick  <= bus.wdata[15:0];
        end else if (presc == PW'(TICK_CYCLES - 1)) begin
            presc <= '0;
            tick  <= tick + 16'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end
`else
    logic unused_tick_cfg;
    assign unused_tick_cfg = ^TICK_CYCLES;
`endif

    // Load data; only meaningful while sel=1.
    always_comb begin
        rdata_c = IO_UNMAPPED;
        case (bus.addr)
            IO_KDATA: rdata_c = {12'h0, key_deb};
            IO_SDATA: rdata_c = {6'h0, sw_deb};
            IO_KCTRL: rdata_c = ctrl_word(kctrl);
            IO_SCTRL: rdata_c = ctrl_word(sctrl);
            IO_HEX:   rdata_c = hex_out;
            IO_LEDR:  rdata_c = {6'h0, ledr_out};
            IO_LEDG:  rdata_c = {8'h0, ledg_out};
`ifdef IO_TICK_TIMER_EN
            IO_TICK:  rdata_c = tick;
`endif
            default:  rdata_c = IO_UNMAPPED;
        endcase
    end

    assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: directed self-checking bench for io_responder
// (DEBOUNCE_CYCLES=4, TICK_CYCLES=3).
module tb_io_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_in;
    logic [9:0] sw_in;
    logic [15:0] hex_out;
    logic [9:0]  ledr_out;
    logic [7:0]  ledg_out;

    int n_chk  = 0;
    int n_fail = 0;

    io_responder_if #(.DBITS(16)) bus ();

    io_responder #(.DBITS(16), .DEBOUNCE_CYCLES(4), .TICK_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .key_in(key_in), .sw_in(sw_in),
        .hex_out(hex_out), .ledr_out(ledr_out), .ledg_out(ledg_out)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rd(input string tag, input logic [15:0] a, input logic [15:0] exp);
        bus.addr = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.we    = 1'b1;
        step(1);
        bus.we    = 1'b0;
    endtask

    task automatic rd_clr(input logic [15:0] a);
        bus.addr = a;
        bus.re   = 1'b1;
        step(1);
        bus.re   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;  key_in = 4'hF;  sw_in = 10'h0;
        bus.addr = 16'hFFF0;  bus.wdata = 16'h0;  bus.we = 1'b0;  bus.re = 1'b0;
        step(3);
        rst_n = 1'b1;
        step(1);

        // Reset state
        chk("rst_hex",  hex_out, 16'h0000);
        chk("rst_ledr", {6'h0, ledr_out}, 16'h0000);
        chk("rst_ledg", {8'h0, ledg_out}, 16'h0000);
        chk_rd("rst_kdata", 16'hFFF0, 16'h000F);
        chk_rd("rst_sdata", 16'hFFF2, 16'h0000);
        chk_rd("rst_kctrl", 16'hFFF4, 16'h0000);
        chk_rd("rst_sctrl", 16'hFFF6, 16'h0000);

        // Key debounce: 6 cycles pin-to-register
        step(1);
        key_in = 4'hE;
        step(5);
        chk_rd("deb_kdata_5", 16'hFFF0, 16'h000F);
        chk_rd("deb_kctrl_5", 16'hFFF4, 16'h0000);
        step(1);
        chk_rd("deb_kdata_6", 16'hFFF0, 16'h000E);
        chk_rd("deb_kctrl_6", 16'hFFF4, 16'h0001);
        rd_clr(16'hFFF0);
        chk_rd("kread_clr", 16'hFFF4, 16'h0000);
        key_in = 4'hF;
        step(8);
        chk_rd("key_back_data", 16'hFFF0, 16'h000F);
        chk_rd("key_back_ctrl", 16'hFFF4, 16'h0001);
        rd_clr(16'hFFF0);

        // 3-cycle glitch is filtered
        key_in = 4'hE;
        step(3);
        key_in = 4'hF;
        step(10);
        chk_rd("glitch_kdata", 16'hFFF0, 16'h000F);
        chk_rd("glitch_kctrl", 16'hFFF4, 16'h0000);

        // Switch read-clear / overrun
        sw_in = 10'h155;
        step(8);
        chk_rd("sw1_sdata", 16'hFFF2, 16'h0155);
        chk_rd("sw1_sctrl", 16'hFFF6, 16'h0001);
        sw_in = 10'h2AA;
        step(8);
        chk_rd("sw2_sctrl", 16'hFFF6, 16'h0005);
        wr(16'hFFF6, 16'h0004);
        chk_rd("sctrl_wr_keep", 16'hFFF6, 16'h0005);
        rd_clr(16'hFFF2);
        chk_rd("sctrl_rd_clr", 16'hFFF6, 16'h0004);
        wr(16'hFFF6, 16'h0000);
        chk_rd("sctrl_wr_clr", 16'hFFF6, 16'h0000);

        // Update and clearing read on the same edge
        key_in = 4'hE;
        step(8);
        chk_rd("sim_pre_ctrl", 16'hFFF4, 16'h0001);
        key_in = 4'hF;
        step(5);
        rd_clr(16'hFFF0);
        chk_rd("sim_kctrl", 16'hFFF4, 16'h0001);
        chk_rd("sim_kdata", 16'hFFF0, 16'h000F);

        // Output registers
        wr(16'hFFF8, 16'hBEEF);
        chk("hex_out", hex_out, 16'hBEEF);
        wr(16'hFFFA, 16'hFFFF);
        chk("ledr_out", {6'h0, ledr_out}, 16'h03FF);
        wr(16'hFFFC, 16'h00A5);
        chk("ledg_out", {8'h0, ledg_out}, 16'h00A5);
        chk_rd("rb_hex",  16'hFFF8, 16'hBEEF);
        chk_rd("rb_ledr", 16'hFFFA, 16'h03FF);
        chk_rd("rb_ledg", 16'hFFFC, 16'h00A5);
        chk_rd("sw_read", 16'hFFF2, 16'h02AA);
        chk("sel_in", {15'h0, bus.sel}, 16'h0001);
        chk_rd("odd_unmapped", 16'hFFF1, 16'hDEAD);
        wr(16'hFFF0, 16'h0000);
        chk_rd("kdata_ro", 16'hFFF0, 16'h000F);
        wr(16'h1238, 16'h1111);
        chk("sel_out", {15'h0, bus.sel}, 16'h0000);
        chk("wr_nosel", hex_out, 16'hBEEF);

`ifdef IO_TICK_TIMER_EN
        wr(16'hFFFE, 16'hFFFF);
        step(3);
        chk_rd("tick_wrap", 16'hFFFE, 16'h0000);
        step(9);
        chk_rd("tick_3", 16'hFFFE, 16'h0003);
`else
        chk_rd("tick_unmapped", 16'hFFFE, 16'hDEAD);
        wr(16'hFFFE, 16'h1234);
        chk_rd("tick_wr_ign", 16'hFFFE, 16'hDEAD);
`endif

        // Mid-run reset, with a key change pending in the debouncer
        sw_in  = 10'h0;
        key_in = 4'h3;
        step(4);
        rst_n = 1'b0;
        #1;
        chk("mrst_hex",  hex_out, 16'h0000);
        chk("mrst_ledr", {6'h0, ledr_out}, 16'h0000);
        chk("mrst_ledg", {8'h0, ledg_out}, 16'h0000);
        chk_rd("mrst_kdata", 16'hFFF0, 16'h000F);
        chk_rd("mrst_sdata", 16'hFFF2, 16'h0000);
        chk_rd("mrst_kctrl", 16'hFFF4, 16'h0000);
        chk_rd("mrst_sctrl", 16'hFFF6, 16'h0000);
        key_in = 4'hF;
        step(2);
        rst_n = 1'b1;
        step(8);
        chk_rd("mrst_discard", 16'hFFF0, 16'h000F);
        chk_rd("mrst_kctrl2",  16'hFFF4, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
